// File: rtl/jtag_scan_sequencer.sv
// JTAG master: issues TAP reset / idle / IR / DR scan commands as TCK/TMS/TDI
// sequences, captures TDO and tracks a shadow copy of the target TAP state.
module jtag_scan_sequencer #(
  parameter int DATA_W  = 32,
  parameter int LEN_W   = 6,
  parameter int CLK_DIV = 2
) (
  input  logic              CLK,
  input  logic              TRST,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_type,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic [DATA_W-1:0] cmd_data,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              TCK_O,
  output logic              TMS_O,
  output logic              TDI_O,
  input  logic              TDO_I,
  output logic [3:0]        tap_state,
  output logic              busy
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  typedef enum logic [2:0] {S_IDLE, S_PRE, S_HEAD, S_SHIFT, S_TAIL, S_RESP} state_t;
  typedef enum logic [1:0] {CMD_RESET, CMD_IDLE, CMD_SCAN_IR, CMD_SCAN_DR} cmd_t;
  typedef enum logic [3:0] {
    TAP_TLR, TAP_RTI, TAP_SEL_DR, TAP_CAP_DR, TAP_SH_DR, TAP_EX1_DR, TAP_PA_DR, TAP_EX2_DR,
    TAP_UPD_DR, TAP_SEL_IR, TAP_CAP_IR, TAP_SH_IR, TAP_EX1_IR, TAP_PA_IR, TAP_EX2_IR, TAP_UPD_IR
  } tap_t;

  state_t             state;
  tap_t               tap_q, tap_nxt;
  cmd_t               typ_q;
  logic               ready_q, launch, cap_en;
  logic [DIV_W-1:0]   div_cnt;
  logic [LEN_W-1:0]   len_q, pat_cnt, bit_cnt, cap_idx, len_eff, head_len;
  logic [DATA_W-1:0]  data_q, shifted;
  logic               head_tms, head_done, shift_done, last_shift, shift_tdi;
  logic               is_scan, div_last, decide, fin;

  assign tap_state = tap_q;
  assign cmd_ready = ready_q & ~busy & ~rsp_valid;
  assign len_eff   = (int'(cmd_len) > DATA_W) ? LEN_W'(DATA_W) : cmd_len;

  always_comb begin
    tap_nxt = tap_q;
    unique case (tap_q)
      TAP_TLR:    tap_nxt = TMS_O ? TAP_TLR    : TAP_RTI;
      TAP_RTI:    tap_nxt = TMS_O ? TAP_SEL_DR : TAP_RTI;
      TAP_SEL_DR: tap_nxt = TMS_O ? TAP_SEL_IR : TAP_CAP_DR;
      TAP_CAP_DR: tap_nxt = TMS_O ? TAP_EX1_DR : TAP_SH_DR;
      TAP_SH_DR:  tap_nxt = TMS_O ? TAP_EX1_DR : TAP_SH_DR;
      TAP_EX1_DR: tap_nxt = TMS_O ? TAP_UPD_DR : TAP_PA_DR;
      TAP_PA_DR:  tap_nxt = TMS_O ? TAP_EX2_DR : TAP_PA_DR;
      TAP_EX2_DR: tap_nxt = TMS_O ? TAP_UPD_DR : TAP_SH_DR;
      TAP_UPD_DR: tap_nxt = TMS_O ? TAP_SEL_DR : TAP_RTI;
      TAP_SEL_IR: tap_nxt = TMS_O ? TAP_TLR    : TAP_CAP_IR;
      TAP_CAP_IR: tap_nxt = TMS_O ? TAP_EX1_IR : TAP_SH_IR;
      TAP_SH_IR:  tap_nxt = TMS_O ? TAP_EX1_IR : TAP_SH_IR;
      TAP_EX1_IR: tap_nxt = TMS_O ? TAP_UPD_IR : TAP_PA_IR;
      TAP_PA_IR:  tap_nxt = TMS_O ? TAP_EX2_IR : TAP_PA_IR;
      TAP_EX2_IR: tap_nxt = TMS_O ? TAP_UPD_IR : TAP_SH_IR;
      TAP_UPD_IR: tap_nxt = TMS_O ? TAP_SEL_DR : TAP_RTI;
    endcase
  end

  // Head pattern per command: RESET 111110, IDLE L zeros, DR 100, IR 1100.
  always_comb begin
    head_len = '0;
    head_tms = 1'b0;
    unique case (typ_q)
      CMD_RESET:   begin head_len = LEN_W'(6); head_tms = (pat_cnt < LEN_W'(5)); end
      CMD_IDLE:    head_len = len_q;
      CMD_SCAN_IR: begin head_len = LEN_W'(4); head_tms = (pat_cnt < LEN_W'(2)); end
      CMD_SCAN_DR: begin head_len = LEN_W'(3); head_tms = (pat_cnt == '0); end
    endcase
  end

  assign is_scan    = typ_q[1];
  assign head_done  = (pat_cnt == head_len);
  assign shift_done = (bit_cnt == len_q);
  assign last_shift = (bit_cnt == len_q - LEN_W'(1));
  assign shifted    = data_q >> bit_cnt;
  assign shift_tdi  = shifted[0];
  assign div_last   = (div_cnt == DIV_W'(CLK_DIV - 1));
  // A decision point is the edge that opens a TCK low phase (or the launch
  // edge right after accept); at each one the next bit is chosen or the
  // command completes.
  assign decide     = launch | (TCK_O & div_last);
  assign fin        = decide & (((state == S_HEAD) & (is_scan ? (len_q == '0) : head_done)) |
                                ((state == S_TAIL) & (pat_cnt != '0)));

  always_ff @(posedge CLK or posedge TRST) begin
    if (TRST) begin
      state     <= S_IDLE;
      tap_q     <= TAP_TLR;
      typ_q     <= CMD_RESET;
      ready_q   <= 1'b0;
      launch    <= 1'b0;
      cap_en    <= 1'b0;
      div_cnt   <= '0;
      len_q     <= '0;
      pat_cnt   <= '0;
      bit_cnt   <= '0;
      cap_idx   <= '0;
      data_q    <= '0;
      TCK_O     <= 1'b0;
      TMS_O     <= 1'b1;
      TDI_O     <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      busy      <= 1'b0;
    end else begin
      ready_q <= 1'b1;
      unique case (state)
        S_IDLE: begin
          TCK_O <= 1'b0;
          TDI_O <= 1'b0;
          TMS_O <= (tap_q != TAP_RTI);
          if (cmd_valid && cmd_ready) begin
            typ_q    <= cmd_t'(cmd_type);
            len_q    <= len_eff;
            data_q   <= cmd_data;
            rsp_data <= '0;
            busy     <= 1'b1;
            launch   <= 1'b1;
            cap_en   <= 1'b0;
            div_cnt  <= '0;
            pat_cnt  <= '0;
            bit_cnt  <= '0;
            state    <= (cmd_type[1] && tap_q == TAP_TLR && len_eff != '0) ? S_PRE : S_HEAD;
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: begin
          if (fin) begin
            launch    <= 1'b0;
            cap_en    <= 1'b0;
            TCK_O     <= 1'b0;
            TDI_O     <= 1'b0;
            TMS_O     <= (tap_q != TAP_RTI);
            busy      <= 1'b0;
            rsp_valid <= 1'b1;
            state     <= S_RESP;
          end else if (decide) begin
            launch  <= 1'b0;
            TCK_O   <= 1'b0;
            div_cnt <= '0;
            cap_en  <= 1'b0;
            TDI_O   <= 1'b0;
            case (state)
              S_PRE: begin
                TMS_O <= 1'b0;
                state <= S_HEAD;
              end
              S_HEAD, S_SHIFT: begin
                if (state == S_HEAD && !head_done) begin
                  TMS_O   <= head_tms;
                  pat_cnt <= pat_cnt + 1'b1;
                end else if (!shift_done) begin
                  TMS_O   <= last_shift;
                  TDI_O   <= shift_tdi;
                  cap_en  <= 1'b1;
                  cap_idx <= bit_cnt;
                  bit_cnt <= bit_cnt + 1'b1;
                  state   <= S_SHIFT;
                end else begin
                  TMS_O   <= 1'b1;
                  pat_cnt <= '0;
                  state   <= S_TAIL;
                end
              end
              default: begin
                TMS_O   <= 1'b0;
                pat_cnt <= LEN_W'(1);
              end
            endcase
          end else if (div_last) begin
            div_cnt <= '0;
            TCK_O   <= ~TCK_O;
            if (!TCK_O) begin
              tap_q <= tap_nxt;
              if (cap_en)
                rsp_data <= rsp_data | (DATA_W'(TDO_I) << cap_idx);
            end
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_jtag_scan_sequencer.sv
// Scoreboard bench for jtag_scan_sequencer: expected TCK/TMS traces, captured
// data and TAP states are queued at issue and compared at each response.
module tb_jtag_scan_sequencer;
  localparam int DATA_W  = 32;
  localparam int LEN_W   = 6;
  localparam int CLK_DIV = 2;

  logic              CLK = 1'b0;
  logic              TRST = 1'b1;
  logic              cmd_valid = 1'b0;
  logic              cmd_ready;
  logic [1:0]        cmd_type = 2'd0;
  logic [LEN_W-1:0]  cmd_len = '0;
  logic [DATA_W-1:0] cmd_data = '0;
  logic              rsp_valid;
  logic              rsp_ready = 1'b0;
  logic [DATA_W-1:0] rsp_data;
  logic              TCK_O, TMS_O, TDI_O, TDO_I;
  logic [3:0]        tap_state;
  logic              busy;
  logic [1:0]        tdo_mode = 2'd0;

  assign TDO_I = (tdo_mode == 2'd2) ? TDI_O : tdo_mode[0];

  always #5 CLK = ~CLK;

  jtag_scan_sequencer #(.DATA_W(DATA_W), .LEN_W(LEN_W), .CLK_DIV(CLK_DIV)) dut (
    .CLK(CLK), .TRST(TRST), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_type(cmd_type), .cmd_len(cmd_len), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .TCK_O(TCK_O), .TMS_O(TMS_O), .TDI_O(TDI_O), .TDO_I(TDO_I),
    .tap_state(tap_state), .busy(busy)
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference IEEE 1149.1 TAP graph driven by the observed TCK/TMS pins.
  function automatic logic [3:0] tap_next(input logic [3:0] s, input logic tms);
    case (s)
      4'h0: return tms ? 4'h0 : 4'h1;
      4'h1: return tms ? 4'h2 : 4'h1;
      4'h2: return tms ? 4'h9 : 4'h3;
      4'h3: return tms ? 4'h5 : 4'h4;
      4'h4: return tms ? 4'h5 : 4'h4;
      4'h5: return tms ? 4'h8 : 4'h6;
      4'h6: return tms ? 4'h7 : 4'h6;
      4'h7: return tms ? 4'h8 : 4'h4;
      4'h8: return tms ? 4'h2 : 4'h1;
      4'h9: return tms ? 4'h0 : 4'hA;
      4'hA: return tms ? 4'hC : 4'hB;
      4'hB: return tms ? 4'hC : 4'hB;
      4'hC: return tms ? 4'hF : 4'hD;
      4'hD: return tms ? 4'hE : 4'hD;
      4'hE: return tms ? 4'hF : 4'hB;
      default: return tms ? 4'h2 : 4'h1;
    endcase
  endfunction

  logic [3:0] mtap = 4'h0;
  int         tck_n = 0;
  int         sir_cnt = 0;
  logic       tms_log [0:1023];

  always @(posedge TCK_O or posedge TRST) begin
    if (TRST) mtap = 4'h0;
    else begin
      if (tck_n < 1024) tms_log[tck_n] = TMS_O;
      tck_n = tck_n + 1;
      mtap = tap_next(mtap, TMS_O);
    end
  end

  always @(negedge CLK) if (tap_state == 4'hB) sir_cnt = sir_cnt + 1;

  typedef struct {
    logic [63:0] data;
    int          n;
    logic [63:0] tms;
    logic [3:0]  tap;
    int          base;
  } exp_t;
  exp_t sb[$];
  int   lat;

  task automatic build_tms(input logic [1:0] t, input int L, input bit pre,
                           output logic [63:0] seq, output int n);
    seq = '0;
    n = 0;
    if (t == 2'd0) begin
      for (int i = 0; i < 6; i++) begin seq[n] = (i < 5); n++; end
    end else if (t == 2'd1) begin
      n = L;
    end else if (L > 0) begin
      if (pre) n++;
      seq[n] = 1'b1; n++;
      if (t == 2'd2) begin seq[n] = 1'b1; n++; end
      n += 2;
      n += L - 1;
      seq[n] = 1'b1; n++;
      seq[n] = 1'b1; n++;
      n++;
    end
  endtask

  task automatic send(input logic [1:0] t, input int len, input logic [31:0] d, input bit push);
    int L;
    int w;
    exp_t e;
    logic [63:0] mask;
    L = (len > DATA_W) ? DATA_W : len;
    build_tms(t, L, (t[1] && L > 0 && mtap == 4'h0), e.tms, e.n);
    mask = (L >= 32) ? 64'hFFFF_FFFF : ((64'd1 << L) - 64'd1);
    if (!t[1]) e.data = '0;
    else if (tdo_mode == 2'd0) e.data = '0;
    else if (tdo_mode == 2'd1) e.data = mask;
    else e.data = {32'd0, d} & mask;
    e.tap  = (L == 0 && t != 2'd0) ? mtap : 4'h1;
    e.base = tck_n;
    if (push) sb.push_back(e);
    @(negedge CLK);
    cmd_type = t; cmd_len = LEN_W'(len); cmd_data = d; cmd_valid = 1'b1;
    w = 0;
    while (!cmd_ready && w < 100) begin @(negedge CLK); w++; end
    if (!cmd_ready) chk("accept_wait", {63'd0, cmd_ready}, 64'd1);
    @(posedge CLK);
    @(negedge CLK);
    cmd_valid = 1'b0;
    lat = 1;
  endtask

  task automatic wait_rsp();
    int w;
    logic [63:0] got;
    exp_t e;
    w = 0;
    while (!rsp_valid && w < 3000) begin @(negedge CLK); w++; lat++; end
    chk("rsp_valid", {63'd0, rsp_valid}, 64'd1);
    if (sb.size() > 0 && rsp_valid) begin
      e = sb.pop_front();
      chk("rsp_data", {32'd0, rsp_data}, e.data);
      chk("tck_count", 64'(tck_n - e.base), 64'(e.n));
      got = '0;
      for (int i = 0; i < e.n && i < 64; i++) got[i] = tms_log[e.base + i];
      chk("tms_seq", got, e.tms);
      chk("tap_state", {60'd0, tap_state}, {60'd0, e.tap});
      chk("tap_graph", {60'd0, tap_state}, {60'd0, mtap});
      chk("busy_done", {63'd0, busy}, 64'd0);
      chk("tck_idle", {63'd0, TCK_O}, 64'd0);
    end
  endtask

  task automatic ack();
    rsp_ready = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    rsp_ready = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got time limit, expected completion");
    $fatal(1);
  end

  initial begin
    int cnt;
    int w;
    logic [31:0] snap;
    logic [31:0] d;

    repeat (3) @(negedge CLK);
    chk("rst_tck", {63'd0, TCK_O}, 64'd0);
    chk("rst_tms", {63'd0, TMS_O}, 64'd1);
    chk("rst_tdi", {63'd0, TDI_O}, 64'd0);
    chk("rst_ready", {63'd0, cmd_ready}, 64'd0);
    chk("rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
    chk("rst_rsp_data", {32'd0, rsp_data}, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_tap", {60'd0, tap_state}, 64'd0);
    TRST = 1'b0;
    @(negedge CLK);
    chk("ready_after_rst", {63'd0, cmd_ready}, 64'd1);

    // Abort a 16-bit DR scan in the middle of shifting.
    tdo_mode = 2'd2;
    send(2'd3, 16, 32'h1234_5678, 1'b0);
    w = 0;
    while (tap_state != 4'h4 && w < 200) begin @(negedge CLK); w++; end
    repeat (6) @(negedge CLK);
    chk("mid_shift", {60'd0, tap_state}, 64'h4);
    TRST = 1'b1;
    #2;
    chk("abort_tck", {63'd0, TCK_O}, 64'd0);
    chk("abort_tms", {63'd0, TMS_O}, 64'd1);
    chk("abort_tap", {60'd0, tap_state}, 64'd0);
    chk("abort_busy", {63'd0, busy}, 64'd0);
    chk("abort_ready", {63'd0, cmd_ready}, 64'd0);
    @(negedge CLK);
    TRST = 1'b0;
    @(negedge CLK);
    chk("abort_ready_rel", {63'd0, cmd_ready}, 64'd1);
    cnt = 0;
    repeat (20) begin @(negedge CLK); if (rsp_valid) cnt++; end
    chk("abort_no_rsp", 64'(cnt), 64'd0);

    // TAP reset command, then DR loopback.
    send(2'd0, 0, 32'hFFFF_FFFF, 1'b1);
    wait_rsp(); ack();
    send(2'd3, 8, 32'h0000_00A5, 1'b1);
    wait_rsp(); ack();

    // IR scan straight after reset: preamble plus 10 TCK, TDO tied high.
    @(negedge CLK); TRST = 1'b1;
    @(negedge CLK); TRST = 1'b0;
    tdo_mode = 2'd1;
    cnt = sir_cnt;
    send(2'd2, 4, 32'hE, 1'b1);
    wait_rsp(); ack();
    chk("saw_shift_ir", {63'd0, sir_cnt > cnt}, 64'd1);

    // Zero-length scan and idle: no TCK, response on the second cycle.
    tdo_mode = 2'd2;
    send(2'd3, 0, 32'hDEAD_BEEF, 1'b1);
    wait_rsp();
    chk("lat_scan0", 64'(lat), 64'd2);
    ack();
    send(2'd1, 0, 32'h0, 1'b1);
    wait_rsp();
    chk("lat_idle0", 64'(lat), 64'd2);
    ack();

    // Over-long scan clamps to DATA_W shifts; idle clocking.
    send(2'd3, 40, 32'hC3A5_5A3C, 1'b1);
    wait_rsp(); ack();
    send(2'd1, 5, 32'hFFFF_FFFF, 1'b1);
    wait_rsp(); ack();

    for (int k = 0; k < 4; k++) begin
      tdo_mode = 2'($urandom_range(0, 2));
      d = $urandom;
      send(2'd2 + 2'($urandom_range(0, 1)), $urandom_range(1, 32), d, 1'b1);
      wait_rsp(); ack();
    end

    // Response backpressure with a competing command held on cmd_valid.
    tdo_mode = 2'd2;
    send(2'd3, 12, 32'h0000_0ABC, 1'b1);
    wait_rsp();
    snap = rsp_data;
    send_hold_prep();
    cnt = 0;
    repeat (20) begin
      @(negedge CLK);
      if (!rsp_valid || rsp_data !== snap || cmd_ready || busy) cnt++;
    end
    chk("hold_stable", 64'(cnt), 64'd0);
    chk("hold_data", {32'd0, rsp_data}, 64'h0ABC);
    rsp_ready = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    rsp_ready = 1'b0;
    chk("ack_ready", {63'd0, cmd_ready}, 64'd1);
    chk("ack_not_busy", {63'd0, busy}, 64'd0);
    @(negedge CLK);
    chk("accept_after_ack", {63'd0, busy}, 64'd1);
    cmd_valid = 1'b0;
    lat = 1;
    wait_rsp(); ack();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Queues an IDLE(3) and raises cmd_valid while the previous response is held.
  task automatic send_hold_prep();
    exp_t e;
    build_tms(2'd1, 3, 1'b0, e.tms, e.n);
    e.data = '0;
    e.tap  = 4'h1;
    e.base = tck_n;
    sb.push_back(e);
    cmd_type = 2'd1; cmd_len = LEN_W'(3); cmd_data = '1; cmd_valid = 1'b1;
  endtask

endmodule

// File: doc/jtag_scan_sequencer.md
Name: jtag_scan_sequencer

Overview:
- JTAG master that drives TCK/TMS/TDI toward a TAP controller and samples TDO.
- Accepts one command at a time (TAP reset, idle clocking, IR scan, DR scan) over a valid/ready interface and returns captured TDO data over a valid/ready response interface.
- Keeps a shadow copy of the target TAP state, using the codebase's 4-bit TAP encoding (Test_Logic_Reset=0000 … Update_IR=1111).

Parameters:
- DATA_W, 32, maximum scan length in bits and width of cmd_data/rsp_data.
- LEN_W, 6, width of cmd_len; must be able to represent DATA_W.
- CLK_DIV, 2, CLK cycles per TCK half-period; must be ≥1.

Ports:
- CLK  in  1  system clock.
- TRST  in  1  reset, asynchronous, active-high.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  sequencer accepts a command.
- cmd_type  in  2  00=RESET, 01=IDLE, 10=SCAN_IR, 11=SCAN_DR.
- cmd_len  in  LEN_W  shift length (scans) or TCK count (IDLE).
- cmd_data  in  DATA_W  TDI bits, LSB shifted first.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  response consumed.
- rsp_data  out  DATA_W  captured TDO bits, LSB first; zero above the effective length.
- TCK_O  out  1  generated test clock.
- TMS_O  out  1  test mode select.
- TDI_O  out  1  test data in.
- TDO_I  in  1  test data out from the target.
- tap_state  out  4  shadow TAP state.
- busy  out  1  command in progress.

Behaviour:
- Reset (TRST=1, any time, including mid-command):
  - TCK_O=0, TMS_O=1, TDI_O=0.
  - cmd_ready=0 while TRST is high; cmd_ready=1 on the first CLK cycle after release.
  - rsp_valid=0, rsp_data=0, busy=0, tap_state=0000.
  - Any in-flight command is aborted with no response.
- TCK generation:
  - Each TCK cycle = CLK_DIV CLK cycles low, then CLK_DIV cycles high.
  - TMS_O/TDI_O update only on the CLK edge that starts a low phase.
  - TDO_I is registered, and tap_state advances per the IEEE 1149.1 graph, on the CLK edge where TCK_O rises.
  - TCK_O is 0 whenever the sequencer is not busy.
- Handshake:
  - cmd_ready = not busy and not rsp_valid.
  - Accept occurs on cmd_valid & cmd_ready; cmd fields are latched and busy rises on that edge.
  - The first TCK low phase starts on the next CLK cycle.
  - rsp_valid rises on the CLK cycle after the final TCK high phase ends.
  - rsp_valid and rsp_data are held until rsp_valid & rsp_ready.
  - Every command produces exactly one response; RESET and IDLE return rsp_data=0.
- Effective length L:
  - L = min(cmd_len, DATA_W).
  - L=0 for IDLE/SCAN: no TCK activity; response on the second CLK cycle after accept.
- Preamble: a SCAN command issued while tap_state=Test_Logic_Reset first emits one TMS=0 cycle, reaching Run_Test_Idle.
- TMS sequences (from Run_Test_Idle):
  - RESET: 1,1,1,1,1,0 (6 TCK), from any state; ends in Run_Test_Idle.
  - IDLE: L cycles of TMS=0; ends in Run_Test_Idle.
  - SCAN_DR: 1,0,0, then L shift cycles (TMS=0 except TMS=1 on the last), then 1,0. Total 5+L TCK.
  - SCAN_IR: 1,1,0,0, then L shift cycles as above, then 1,0. Total 6+L TCK.
- Shift cycles:
  - TDI_O = cmd_data[i] for shift i = 0..L-1.
  - The TDO sample at that cycle's rising edge goes to rsp_data[i].
  - TDI_O=0 outside shift cycles.
- Idle TMS_O: 0 when tap_state=Run_Test_Idle, 1 otherwise.
- Controller FSM:
  - States: IDLE, PRE, HEAD, SHIFT, TAIL, RESP.
  - RESET and IDLE commands use HEAD only, with a pattern counter.
  - Transitions: IDLE→PRE|HEAD on accept; PRE→HEAD; HEAD→SHIFT (scans) or RESP; SHIFT→TAIL after L bits; TAIL→RESP; RESP→IDLE on rsp_ready.
- cmd_valid asserted while busy is ignored; no queuing.

Test Plan:
- TRST pulse mid-SHIFT of a 16-bit DR scan → TCK_O=0, TMS_O=1, tap_state=0000, rsp_valid never asserts; cmd_ready=1 on the first CLK after TRST release.
- After TRST, RESET command → 6 TCK with TMS 111110; tap_state=0001; rsp_data=0.
- From Run_Test_Idle, SCAN_DR L=8, cmd_data=0xA5, TDO_I looped from TDI_O → 13 TCK, TMS 1,0,0,0000000,1,1,0; rsp_data=0x000000A5; tap_state=0001.
- Directly after TRST, SCAN_IR L=4, data=0xE → 11 TCK (preamble plus 10); shadow passes through 1011 (Shift_IR), ends 0001; TDO_I tied 1 → rsp_data=0xF.
- SCAN_DR cmd_len=0 → no TCK edges, response in 2 cycles with rsp_data=0. cmd_len=40 (DATA_W=32) → exactly 32 shift cycles.
- rsp_ready held low 20 cycles after a response → rsp_valid and rsp_data stable, cmd_ready=0, a concurrent cmd_valid is not accepted; accepted on the cycle after the rsp handshake.
